// File: rtl/adpll_pkg.sv
// adpll_pkg: shared types and default parameters for the ADPLL loop controller.
//   ctrl_state_t : controller FSM state (IDLE, SEARCH, TRACK)
//   dec_t        : per-window phase decision (NONE, UP, DN)
//   decide()     : maps conditioned up/down flags to a decision
package adpll_pkg;

    localparam int CODE_W_DEF   = 8;
    localparam int SETTLE_DEF   = 8;
    localparam int LOCK_CNT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        TRACK  = 2'd2
    } ctrl_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        UP   = 2'd1,
        DN   = 2'd2
    } dec_t;

    // Both flags seen in one window means the edges straddle each other: no move.
    function automatic dec_t decide(input logic u, input logic d);
        case ({u, d})
            2'b10:   return UP;
            2'b01:   return DN;
            default: return NONE;
        endcase
    endfunction

endpackage

// File: rtl/adpll_loop_ctrl_if.sv
// adpll_loop_ctrl_if: control/observation bundle of the loop controller.
//   en, flagu, flagd        : driven by the system side (master)
//   dco_code, lock, state   : driven by the controller (slave)
interface adpll_loop_ctrl_if
    import adpll_pkg::*;
#(
    parameter int CODE_W = CODE_W_DEF
);
    logic              en;
    logic              flagu;
    logic              flagd;
    logic [CODE_W-1:0] dco_code;
    logic              lock;
    ctrl_state_t       state;

    modport master (output en, flagu, flagd, input dco_code, lock, state);
    modport slave  (input en, flagu, flagd, output dco_code, lock, state);

endinterface

// File: rtl/adpll_loop_ctrl_pfd_flag_sync.sv
// pfd_flag_sync: conditions one asynchronous PFD flag.
//   clk, rst (sync, active low), clr : window-end / idle clear of the sticky bit
//   flag   : raw PFD flag (asynchronous)
//   sync   : flag after a 2-flop synchronizer
//   sticky : set by any synchronized high since the last clr
module pfd_flag_sync (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic flag,
    output logic sync,
    output logic sticky
);
    logic meta;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sticky <= 1'b0;
        end else begin
            meta   <= flag;
            sync   <= meta;
            // The decision ORs in the current sync value, so clearing on the
            // window-end edge loses nothing.
            sticky <= clr ? 1'b0 : (sticky | sync);
        end
    end

endmodule

// File: rtl/adpll_loop_ctrl.sv
// adpll_loop_ctrl: ADPLL digital loop controller.
//   clk      : controller clock
//   rst      : synchronous active-low reset
//   bus      : slave side of adpll_loop_ctrl_if
//              in : en, flagu, flagd   out : dco_code, lock, state
// Binary-search acquisition (CODE_W-1 windows), then +/-1 tracking with a
// lock detector that counts balanced (NONE or reversing) windows.
module adpll_loop_ctrl
    import adpll_pkg::*;
#(
    parameter int CODE_W   = CODE_W_DEF,
    parameter int SETTLE   = SETTLE_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    adpll_loop_ctrl_if.slave  bus
);
    localparam int WCNT_W = $clog2(SETTLE);
    localparam int LCNT_W = $clog2(LOCK_CNT + 1);
    localparam logic [CODE_W-1:0] MID   = CODE_W'(1) << (CODE_W - 1);
    localparam logic [CODE_W-1:0] MAXC  = '1;
    localparam logic [CODE_W-2:0] STEP0 = (CODE_W - 1)'(1) << (CODE_W - 2);

    ctrl_state_t       state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CODE_W-2:0] step_q, step_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    dec_t              prev_q, prev_d;

    logic [1:0] sync_v, sticky_v;  // [0] = up, [1] = down
    logic       win_end;
    logic       clr;
    dec_t       dec;

    assign win_end = (state_q != IDLE) && (wcnt_q == WCNT_W'(SETTLE - 1));
    assign clr     = win_end || (state_q == IDLE);
    assign dec     = decide(sticky_v[0] | sync_v[0], sticky_v[1] | sync_v[1]);

    pfd_flag_sync u_sync [1:0] (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .flag   ({bus.flagd, bus.flagu}),
        .sync   (sync_v),
        .sticky (sticky_v)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            code_q  <= MID;
            step_q  <= STEP0;
            wcnt_q  <= '0;
            lcnt_q  <= '0;
            prev_q  <= NONE;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            step_q  <= step_d;
            wcnt_q  <= wcnt_d;
            lcnt_q  <= lcnt_d;
            prev_q  <= prev_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        step_d  = step_q;
        wcnt_d  = '0;
        lcnt_d  = lcnt_q;
        prev_d  = prev_q;

        if (state_q != IDLE && !win_end)
            wcnt_d = wcnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                code_d = MID;
                step_d = STEP0;
                lcnt_d = '0;
                prev_d = NONE;
                state_d = SEARCH;
            end
            SEARCH: begin
                if (win_end) begin
                    if (dec == UP) code_d = code_q + CODE_W'(step_q);
                    if (dec == DN) code_d = code_q - CODE_W'(step_q);
                    step_d = step_q >> 1;
                    // step==1 is the last search window; start tracking fresh.
                    if (step_q == (CODE_W - 1)'(1)) begin
                        state_d = TRACK;
                        lcnt_d  = '0;
                        prev_d  = NONE;
                    end
                end
            end
            TRACK: begin
                if (win_end) begin
                    if (dec == UP && code_q != MAXC) code_d = code_q + 1'b1;
                    if (dec == DN && code_q != '0)   code_d = code_q - 1'b1;
                    // A repeated direction means we are still slewing, not dithering.
                    if (dec != NONE && dec == prev_q)
                        lcnt_d = '0;
                    else if (lcnt_q != LCNT_W'(LOCK_CNT))
                        lcnt_d = lcnt_q + 1'b1;
                    if (dec != NONE) prev_d = dec;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!bus.en) begin
            state_d = IDLE;
            code_d  = MID;
            step_d  = STEP0;
            wcnt_d  = '0;
            lcnt_d  = '0;
            prev_d  = NONE;
        end
    end

    assign bus.dco_code = code_q;
    assign bus.lock     = (lcnt_q == LCNT_W'(LOCK_CNT));
    assign bus.state    = state_q;

endmodule

// File: tb/tb_adpll_loop_ctrl.sv
module tb_adpll_loop_ctrl;
    import adpll_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    adpll_loop_ctrl_if #(.CODE_W(8)) bus();

    adpll_loop_ctrl #(.CODE_W(8), .SETTLE(8), .LOCK_CNT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0]  code;
        ctrl_state_t st;
        logic        lk;
    } exp_t;

    typedef struct {
        bit   restart;  // reset and re-enable before this window
        bit   hold;     // keep flags asserted across the window end
        logic u;
        logic d;
        exp_t e;
    } vec_t;

    vec_t       tbl[$];
    exp_t       sbq[$];
    int         total = 0;
    int         bad   = 0;
    logic [7:0] cur_code;

    function automatic vec_t v(bit r, bit h, logic u, logic d,
                               logic [7:0] c, ctrl_state_t s, logic l);
        vec_t t;
        t.restart = r; t.hold = h; t.u = u; t.d = d;
        t.e.code = c; t.e.st = s; t.e.lk = l;
        return t;
    endfunction

    function automatic exp_t ex(logic [7:0] c, ctrl_state_t s, logic l);
        exp_t t;
        t.code = c; t.st = s; t.lk = l;
        return t;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_code"},  bus.dco_code,     8'd128);
        chk({tag, "_lock"},  8'(bus.lock),     8'd0);
        chk({tag, "_state"}, 8'(bus.state),    8'(IDLE));
    endtask

    // Reset, then raise en; returns just after the edge that enters SEARCH.
    task automatic start_loop();
        rst = 1'b0; bus.en = 1'b0; bus.flagu = 1'b0; bus.flagd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; bus.en = 1'b1;
        @(posedge clk); #1;
        cur_code = 8'd128;
    endtask

    // One decision window: flags pulsed (or held) from the window start,
    // code checked unchanged one clock before the window end, then the
    // scoreboard entry compared just after the window-end edge.
    task automatic run_window(input logic u, input logic d, input bit hold, input exp_t e);
        exp_t x;
        sbq.push_back(e);
        bus.flagu = u; bus.flagd = d;
        repeat (3) @(posedge clk);
        #1;
        if (!hold) begin bus.flagu = 1'b0; bus.flagd = 1'b0; end
        repeat (4) @(posedge clk);
        #1;
        chk("code_hold", bus.dco_code, cur_code);
        @(posedge clk); #1;
        x = sbq.pop_front();
        chk("code",  bus.dco_code,  x.code);
        chk("state", 8'(bus.state), 8'(x.st));
        chk("lock",  8'(bus.lock),  8'(x.lk));
        cur_code = x.code;
    endtask

    initial begin
        bus.en = 1'b0; bus.flagu = 1'b0; bus.flagd = 1'b0;

        // A: constant up -> binary search to the top, then saturate in TRACK
        tbl.push_back(v(1, 1, 1, 0, 8'd192, SEARCH, 0));
        tbl.push_back(v(0, 1, 1, 0, 8'd224, SEARCH, 0));
        tbl.push_back(v(0, 1, 1, 0, 8'd240, SEARCH, 0));
        tbl.push_back(v(0, 1, 1, 0, 8'd248, SEARCH, 0));
        tbl.push_back(v(0, 1, 1, 0, 8'd252, SEARCH, 0));
        tbl.push_back(v(0, 1, 1, 0, 8'd254, SEARCH, 0));
        tbl.push_back(v(0, 1, 1, 0, 8'd255, TRACK,  0));
        tbl.push_back(v(0, 1, 1, 0, 8'd255, TRACK,  0));
        tbl.push_back(v(0, 1, 1, 0, 8'd255, TRACK,  0));
        // B: constant down -> bottom, then 0 and hold
        tbl.push_back(v(1, 1, 0, 1, 8'd64,  SEARCH, 0));
        tbl.push_back(v(0, 1, 0, 1, 8'd32,  SEARCH, 0));
        tbl.push_back(v(0, 1, 0, 1, 8'd16,  SEARCH, 0));
        tbl.push_back(v(0, 1, 0, 1, 8'd8,   SEARCH, 0));
        tbl.push_back(v(0, 1, 0, 1, 8'd4,   SEARCH, 0));
        tbl.push_back(v(0, 1, 0, 1, 8'd2,   SEARCH, 0));
        tbl.push_back(v(0, 1, 0, 1, 8'd1,   TRACK,  0));
        tbl.push_back(v(0, 1, 0, 1, 8'd0,   TRACK,  0));
        tbl.push_back(v(0, 1, 0, 1, 8'd0,   TRACK,  0));
        // C: both flags each window -> code parked, NONE windows build lock
        for (int i = 0; i < 7; i++)
            tbl.push_back(v(i == 0, 0, 1, 1, 8'd128, (i == 6) ? TRACK : SEARCH, 0));
        tbl.push_back(v(0, 0, 1, 1, 8'd128, TRACK, 0));
        tbl.push_back(v(0, 0, 1, 1, 8'd128, TRACK, 0));
        tbl.push_back(v(0, 0, 1, 1, 8'd128, TRACK, 0));
        tbl.push_back(v(0, 0, 1, 1, 8'd128, TRACK, 1));
        // D: steer to 100, dither to lock, then repeat direction drops it
        tbl.push_back(v(1, 0, 0, 0, 8'd128, SEARCH, 0));
        tbl.push_back(v(0, 0, 0, 1, 8'd96,  SEARCH, 0));
        tbl.push_back(v(0, 0, 0, 0, 8'd96,  SEARCH, 0));
        tbl.push_back(v(0, 0, 0, 0, 8'd96,  SEARCH, 0));
        tbl.push_back(v(0, 0, 1, 0, 8'd100, SEARCH, 0));
        tbl.push_back(v(0, 0, 0, 0, 8'd100, SEARCH, 0));
        tbl.push_back(v(0, 0, 0, 0, 8'd100, TRACK,  0));
        tbl.push_back(v(0, 0, 1, 0, 8'd101, TRACK,  0));
        tbl.push_back(v(0, 0, 0, 1, 8'd100, TRACK,  0));
        tbl.push_back(v(0, 0, 1, 0, 8'd101, TRACK,  0));
        tbl.push_back(v(0, 0, 0, 1, 8'd100, TRACK,  1));
        tbl.push_back(v(0, 0, 1, 0, 8'd101, TRACK,  1));
        tbl.push_back(v(0, 0, 1, 0, 8'd102, TRACK,  0));

        // Reset state, and en low keeps it even with a flag active
        @(posedge clk); #1;
        chk_reset_vals("rst");
        rst = 1'b1; bus.flagu = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk_reset_vals("en_low");
        bus.flagu = 1'b0;

        foreach (tbl[i]) begin
            if (tbl[i].restart) start_loop();
            run_window(tbl[i].u, tbl[i].d, tbl[i].hold, tbl[i].e);
        end

        // Rebuild lock from the D end point, then drop en with lock high
        run_window(0, 1, 0, ex(8'd101, TRACK, 0));
        run_window(1, 0, 0, ex(8'd102, TRACK, 0));
        run_window(0, 1, 0, ex(8'd101, TRACK, 0));
        run_window(1, 0, 0, ex(8'd102, TRACK, 1));
        bus.en = 1'b0;
        @(posedge clk); #1;
        chk_reset_vals("en_drop");

        // Reset mid-way through search window 3
        start_loop();
        run_window(1, 0, 1, ex(8'd192, SEARCH, 0));
        run_window(1, 0, 1, ex(8'd224, SEARCH, 0));
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk_reset_vals("mid_rst");
        rst = 1'b1; bus.en = 1'b0; bus.flagu = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
